// File: rtl/vram_arbiter.sv
// Frame-buffer arbiter: shares one single-port RAM between the display and two writers.
// Slots follow p_tick: slot 0 is the display read, slots 1-3 go to the writers.
// During blanking, slot 0 is also a writer slot.
// Writers 0 (game) and 1 (overlay) are granted round-robin.
// Optional screen clear is compiled in with the VRAM_CLEAR_EN macro.
module vram_arbiter #(
    parameter int FB_W        = 160,
    parameter int FB_H        = 120,
    parameter int SCALE_SHIFT = 2,
    parameter int DW          = 12,
    parameter int AW          = 15
) (
    input  logic          clk_100MHz,
    input  logic          reset,
    input  logic          p_tick,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic          video_on,
    input  logic          wr0_valid,
    input  logic [7:0]    wr0_x,
    input  logic [6:0]    wr0_y,
    input  logic [DW-1:0] wr0_data,
    output logic          wr0_ready,
    input  logic          wr1_valid,
    input  logic [7:0]    wr1_x,
    input  logic [6:0]    wr1_y,
    input  logic [DW-1:0] wr1_data,
    output logic          wr1_ready,
    input  logic          clear_start,
    input  logic [DW-1:0] clear_color,
    output logic          clear_busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] rgb,
    output logic          video_on_d
);

    localparam logic [AW:0] FB_W_L = (AW+1)'(FB_W);
    localparam logic [AW:0] FB_H_L = (AW+1)'(FB_H);

    logic [1:0]    r_ph;
    logic          r_rr;
    logic [DW-1:0] r_pix;
    logic          r_vidS;
    logic [AW-1:0] r_addrHold;
    logic [DW-1:0] r_wdataHold;

    logic [AW-1:0] w_dispAddr;
    logic [AW-1:0] w_wrAddr0;
    logic [AW-1:0] w_wrAddr1;
    logic          w_inRange0;
    logic          w_inRange1;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_memActive;
    logic [AW-1:0] w_addrNext;
    logic [DW-1:0] w_wdataNext;
    logic          w_clearing;
    logic [AW-1:0] w_clearAddr;
    logic [DW-1:0] w_clearData;

    // Address arithmetic is done one bit wider than the RAM address, then truncated.
    assign w_dispAddr = AW'((AW+1)'(y >> SCALE_SHIFT) * FB_W_L + (AW+1)'(x >> SCALE_SHIFT));
    assign w_wrAddr0  = AW'((AW+1)'(wr0_y) * FB_W_L + (AW+1)'(wr0_x));
    assign w_wrAddr1  = AW'((AW+1)'(wr1_y) * FB_W_L + (AW+1)'(wr1_x));
    assign w_inRange0 = ((AW+1)'(wr0_x) < FB_W_L) && ((AW+1)'(wr0_y) < FB_H_L);
    assign w_inRange1 = ((AW+1)'(wr1_x) < FB_W_L) && ((AW+1)'(wr1_y) < FB_H_L);

    assign mem_addr  = w_addrNext;
    assign mem_wdata = w_wdataNext;

`ifdef VRAM_CLEAR_EN
    typedef enum logic [0:0] {
        IDLE,
        CLEAR
    } clearState_t;

    localparam logic [AW-1:0] CLEAR_LAST = AW'(FB_W * FB_H - 1);

    clearState_t   r_state;
    clearState_t   w_stateNext;
    logic [AW-1:0] r_cptr;
    logic [DW-1:0] r_clearColor;
    logic          w_wrSlot;

    assign w_wrSlot    = !(p_tick && video_on);
    assign w_clearing  = (r_state == CLEAR);
    assign w_clearAddr = r_cptr;
    assign w_clearData = r_clearColor;
    assign clear_busy  = w_clearing;

    // Clear state, fill pointer and latched fill colour.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cptr       <= '0;
            r_clearColor <= '0;
        end else begin
            r_state <= w_stateNext;
            if (r_state == IDLE && clear_start) begin
                r_cptr       <= '0;
                r_clearColor <= clear_color;
            end else if (r_state == CLEAR && w_wrSlot) begin
                r_cptr <= r_cptr + AW'(1);
            end
        end
    end

    // Start a clear on request; finish after the last cell has been written.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (clear_start) w_stateNext = CLEAR;
            CLEAR:   if (w_wrSlot && r_cptr == CLEAR_LAST) w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end
`else
    logic w_unusedClear;

    assign w_unusedClear = ^{clear_start, clear_color};
    assign w_clearing    = 1'b0;
    assign w_clearAddr   = '0;
    assign w_clearData   = '0;
    assign clear_busy    = 1'b0;
`endif

    // Per-clock slot decision: display read, clear write or writer grant.
    // Everything is gated by reset so a write stops the instant reset rises.
    always_comb begin
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        wr0_ready   = 1'b0;
        wr1_ready   = 1'b0;
        mem_we      = 1'b0;
        w_memActive = 1'b0;
        w_addrNext  = r_addrHold;
        w_wdataNext = r_wdataHold;
        if (!reset) begin
            if (p_tick && video_on) begin
                w_memActive = 1'b1;
                w_addrNext  = w_dispAddr;
            end else if (w_clearing) begin
                mem_we      = 1'b1;
                w_memActive = 1'b1;
                w_addrNext  = w_clearAddr;
                w_wdataNext = w_clearData;
            end else if (wr0_valid && (!wr1_valid || !r_rr)) begin
                w_gnt0    = 1'b1;
                wr0_ready = 1'b1;
                if (w_inRange0) begin
                    mem_we      = 1'b1;
                    w_memActive = 1'b1;
                    w_addrNext  = w_wrAddr0;
                    w_wdataNext = wr0_data;
                end
            end else if (wr1_valid) begin
                w_gnt1    = 1'b1;
                wr1_ready = 1'b1;
                if (w_inRange1) begin
                    mem_we      = 1'b1;
                    w_memActive = 1'b1;
                    w_addrNext  = w_wrAddr1;
                    w_wdataNext = wr1_data;
                end
            end
        end
    end

    // Keep the last driven address and data so the RAM bus is quiet when idle.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_addrHold  <= '0;
            r_wdataHold <= '0;
        end else if (w_memActive) begin
            r_addrHold  <= w_addrNext;
            r_wdataHold <= w_wdataNext;
        end
    end

    // Round-robin pointer points at the writer that did not win last time.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_rr <= 1'b0;
        end else if (w_gnt0) begin
            r_rr <= 1'b1;
        end else if (w_gnt1) begin
            r_rr <= 1'b0;
        end
    end

    // Slot phase: p_tick always restarts the count, so slot 1 follows p_tick.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_ph <= 2'd0;
        end else if (p_tick) begin
            r_ph <= 2'd1;
        end else begin
            r_ph <= r_ph + 2'd1;
        end
    end

    // Pixel pipeline: capture the read data in slot 1, present it on the next p_tick.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            r_pix      <= '0;
            r_vidS     <= 1'b0;
            rgb        <= '0;
            video_on_d <= 1'b0;
        end else begin
            if (p_tick) begin
                r_vidS     <= video_on;
                rgb        <= r_vidS ? r_pix : '0;
                video_on_d <= r_vidS;
            end
            if (!p_tick && r_ph == 2'd1) begin
                r_pix <= mem_rdata;
            end
        end
    end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one single-port frame-buffer RAM between display scan-out and two pixel writers.
- Writer 0 is game logic. Writer 1 is the text/overlay engine.
- Display scan-out is driven by the VGA timing generator's p_tick, x, y and video_on.
- Uses a 4-clock slot schedule locked to p_tick. Display reads are guaranteed. Writers are round-robin arbitrated in the remaining slots and in blanking.

Parameters:
- FB_W, 160, frame-buffer width in cells
- FB_H, 120, frame-buffer height in cells
- SCALE_SHIFT, 2, screen pixels per cell edge = 2^SCALE_SHIFT (640/4 = 160)
- DW, 12, colour word width (RGB444)
- AW, 15, RAM address width; must satisfy FB_W*FB_H <= 2^AW

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- p_tick  in  1  pixel tick, high 1 clock in 4
- x  in  10  current pixel column
- y  in  10  current pixel row
- video_on  in  1  active-area flag
- wr0_valid  in  1  writer 0 request
- wr0_x  in  8  writer 0 cell column
- wr0_y  in  7  writer 0 cell row
- wr0_data  in  DW  writer 0 colour
- wr0_ready  out  1  writer 0 accept
- wr1_valid, wr1_x, wr1_y, wr1_data, wr1_ready  (same as writer 0)
- clear_start  in  1  clear request (used only with VRAM_CLEAR_EN)
- clear_color  in  DW  fill colour (used only with VRAM_CLEAR_EN)
- clear_busy  out  1  clear in progress
- mem_addr  out  AW  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, 1-clock synchronous read latency
- rgb  out  DW  pixel colour to DAC
- video_on_d  out  1  video_on delayed to align with rgb

Behaviour:
- Phase counter ph[1:0]
  - Set to 1 on the clock after p_tick=1; increments otherwise; wraps 3 -> 0.
  - A p_tick while ph != 0 forces resynchronisation to phase 0.
- Slot 0 (p_tick=1, video_on=1) is the display read.
  - mem_addr = (y>>SCALE_SHIFT)*FB_W + (x>>SCALE_SHIFT); mem_we=0.
  - All arithmetic is done at AW+1 bits, then truncated to AW.
- Capture: mem_rdata is sampled on slot 1. rgb is loaded on the next p_tick edge, together with video_on_d <= video_on sampled in slot 0.
  - Result: rgb and video_on_d lag x/y by exactly one pixel tick (4 clocks).
  - rgb is forced to 0 when the sampled video_on was 0.
- Writer slots are slots 1-3, plus slot 0 when video_on=0.
- Grant is combinational within the slot:
  - ready is raised only for a requester with valid=1.
  - Only one valid: that writer is granted.
  - Both valid: the writer indicated by the rr pointer is granted.
  - rr flips to the other writer after every grant.
  - A transfer completes when valid & ready are both high in the same clock.
- On a grant: mem_we=1, mem_addr = wrN_y*FB_W + wrN_x, mem_wdata = wrN_data.
- Out-of-range coordinates (wrN_x >= FB_W or wrN_y >= FB_H): ready=1 (request consumed), mem_we=0 (write dropped).
- Writers must hold valid and all payload signals stable until ready. Max wait with both writers busy is 2 clocks.
- Idle (no grant, no display read): mem_we=0, mem_addr holds its last value.
- Reset values: ph=0, rr=0 (writer 0 first), rgb=0, video_on_d=0, wr0_ready=0, wr1_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, clear_busy=0.
- Reset mid-operation immediately aborts any transfer or clear. There is no partial write, because mem_we is cleared asynchronously.

Optional Feature:
- Macro: VRAM_CLEAR_EN.
- With the macro defined:
  - FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on clear_start=1. In the same clock: clear_busy=1, clear pointer cptr=0, clear_color latched.
  - In CLEAR, every writer slot writes the latched colour to cptr, then cptr increments. Writers receive ready=0. Display reads are unaffected.
  - After the write to address FB_W*FB_H-1: state returns to IDLE and clear_busy=0 on the following clock.
  - clear_start while in CLEAR is ignored (the clear does not restart).
- Without the macro: clear_start and clear_color are ignored, clear_busy is tied to 0, and no FSM is synthesised.

Test Plan:
- Display read: after reset, drive p_tick with x=8, y=4, video_on=1 and mem_rdata=0xABC on slot 1.
  -> mem_addr=162 in slot 0; rgb=0xABC and video_on_d=1 on the next p_tick.
- Single writer: wr0_valid=1, wr0_x=5, wr0_y=2, wr0_data=0x0F0.
  -> In the first writer slot: wr0_ready=1, mem_we=1, mem_addr=325, mem_wdata=0x0F0.
- Contention: both writers valid continuously for 12 clocks of active video.
  -> Grants alternate 0,1,0,…; exactly 9 grants, none in slot 0.
- Blanking: video_on=0 with both writers valid for 4 clocks.
  -> 4 grants; mem_we=1 in every slot including slot 0; rgb=0 on the next p_tick.
- Out-of-range write: wr1_x=160, wr1_y=0.
  -> wr1_ready=1, mem_we=0.
- Clear (VRAM_CLEAR_EN): pulse clear_start with clear_color=0x123, hold wr0_valid=1.
  -> Addresses 0..19199 are each written once with 0x123; wr0_ready stays 0 until clear_busy falls.
  -> Assert reset mid-clear: clear_busy=0 and mem_we=0 immediately.
